// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised rx line, mid-bit sampling, LSB-first data,
// one-cycle valid/error strobes. Framing errors are flagged and never delivered.
module uart_rx #(
  parameter int CLK_FREQ   = 10_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_err,
  output logic                  rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BIT_CLKS     = CLKS_PER_BIT + 1;
  localparam int HALF_CLKS    = BIT_CLKS / 2;

  localparam logic [11:0] BIT_LAST  = 12'(BIT_CLKS - 1);
  localparam logic [11:0] HALF_LAST = 12'(HALF_CLKS - 1);
  localparam logic [2:0]  IDX_LAST  = 3'(DATA_WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                  sync1_q, rx_sync_q;
  logic [1:0]            prime_q;
  logic [1:0]            state_q, state_d;
  logic [11:0]           cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  armed_q, armed_d;
  logic                  stop_err_q, stop_err_d;

  // prime_q keeps the reset value of the synchroniser from arming the receiver:
  // only once the real line has propagated through both stages may rx_sync arm it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 1'b1;
      rx_sync_q <= 1'b1;
      prime_q   <= 2'b00;
    end else begin
      sync1_q   <= rx_serial;
      rx_sync_q <= sync1_q;
      prime_q   <= {prime_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    data_d     = data_q;
    armed_d    = armed_q;
    stop_err_d = stop_err_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        stop_err_d = 1'b0;
        if (rx_sync_q && prime_q[1]) begin
          armed_d = 1'b1;
        end else if (!rx_sync_q && armed_q) begin
          state_d = S_START;
          armed_d = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_sync_q;
          if (idx_q == IDX_LAST) state_d = S_STOP;
          else                   idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      S_STOP: begin
        // After a framing error the counter stays frozen until the line idles high.
        if (stop_err_q) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
            armed_d = 1'b1;
          end
        end else if (cnt_q == BIT_LAST) begin
          if (rx_sync_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
            armed_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            stop_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
      stop_err_q <= stop_err_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;
  assign rx_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 9600-baud instance (a) for the main scenarios and a
// 115200-baud instance (b) for the short-bit-period frames.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, err_a, err_b, busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcnt_a = 0, ecnt_a = 0, vcnt_b = 0, ecnt_b = 0;
  int edge_cyc;
  logic [7:0] vdata_a[$];
  logic [7:0] vdata_b[$];
  int         vtime_a[$];

  uart_rx #(.CLK_FREQ(10_000_000), .BAUD_RATE(9600), .DATA_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .rx_serial(rx_a), .rx_data(data_a),
    .rx_valid(valid_a), .rx_err(err_a), .rx_busy(busy_a)
  );

  uart_rx #(.CLK_FREQ(10_000_000), .BAUD_RATE(115200), .DATA_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .rx_serial(rx_b), .rx_data(data_b),
    .rx_valid(valid_b), .rx_err(err_b), .rx_busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobes are counted per cycle, so a pulse wider than one cycle shows up as extra counts.
  always @(negedge clk) begin
    if (valid_a) begin
      vcnt_a++;
      vdata_a.push_back(data_a);
      vtime_a.push_back(cyc);
    end
    if (err_a) ecnt_a++;
    if (valid_b) begin
      vcnt_b++;
      vdata_b.push_back(data_b);
    end
    if (err_b) ecnt_b++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input bit sel, input logic v, input int n);
    if (sel) rx_b = v;
    else     rx_a = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input bit sel, input int bc, input logic [7:0] b,
                       input logic stop_v, input int stop_n);
    edge_cyc = cyc;
    hold(sel, 1'b0, bc);
    for (int i = 0; i < 8; i++) hold(sel, b[i], bc);
    hold(sel, stop_v, stop_n);
  endtask

  initial begin
    int lat;
    int gap;
    rst  = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    #3;
    check("reset_data", data_a, 8'h00);
    check("reset_valid", valid_a, 1'b0);
    check("reset_err", err_a, 1'b0);
    check("reset_busy", busy_a, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    hold(1'b0, 1'b1, 10);

    // 1: single frame 0xA5
    frame(1'b0, 1042, 8'hA5, 1'b1, 1042);
    hold(1'b0, 1'b1, 20);
    check("t1_vcnt", vcnt_a, 1);
    check("t1_vdata", vdata_a[0], 8'hA5);
    check("t1_rx_data", data_a, 8'hA5);
    check("t1_no_err", ecnt_a, 0);
    lat = vtime_a[0] - edge_cyc;
    check("t1_latency_9901_9903", (lat >= 9901 && lat <= 9903), 1'b1);
    check("t1_idle", busy_a, 1'b0);

    // 2: back-to-back 0x00, 0xFF
    frame(1'b0, 1042, 8'h00, 1'b1, 1042);
    frame(1'b0, 1042, 8'hFF, 1'b1, 1042);
    hold(1'b0, 1'b1, 20);
    check("t2_vcnt", vcnt_a, 3);
    check("t2_vdata0", vdata_a[1], 8'h00);
    check("t2_vdata1", vdata_a[2], 8'hFF);
    gap = vtime_a[2] - vtime_a[1];
    check("t2_gap_10419_10421", (gap >= 10419 && gap <= 10421), 1'b1);
    check("t2_no_err", ecnt_a, 0);

    // 3: 300-clock low glitch
    hold(1'b0, 1'b0, 300);
    check("t3_busy_in_glitch", busy_a, 1'b1);
    hold(1'b0, 1'b1, 600);
    check("t3_busy_after", busy_a, 1'b0);
    check("t3_vcnt", vcnt_a, 3);
    check("t3_ecnt", ecnt_a, 0);

    // 4: framing error then recovery
    frame(1'b0, 1042, 8'h3C, 1'b0, 2084);
    check("t4_ecnt", ecnt_a, 1);
    check("t4_vcnt", vcnt_a, 3);
    check("t4_data_kept", data_a, 8'hFF);
    check("t4_busy_while_low", busy_a, 1'b1);
    hold(1'b0, 1'b1, 20);
    check("t4_idle_after_high", busy_a, 1'b0);
    frame(1'b0, 1042, 8'h12, 1'b1, 1042);
    hold(1'b0, 1'b1, 20);
    check("t4_vcnt_recover", vcnt_a, 4);
    check("t4_data_recover", data_a, 8'h12);
    check("t4_ecnt_final", ecnt_a, 1);

    // 5: reset during data bit 4 of 0xC3, release with line low
    hold(1'b0, 1'b0, 1042);
    hold(1'b0, 1'b1, 1042);
    hold(1'b0, 1'b1, 1042);
    hold(1'b0, 1'b0, 1042);
    hold(1'b0, 1'b0, 1042);
    hold(1'b0, 1'b0, 500);
    check("t5_busy_before_rst", busy_a, 1'b1);
    rst = 1'b0;
    #1;
    check("t5_rst_data", data_a, 8'h00);
    check("t5_rst_valid", valid_a, 1'b0);
    check("t5_rst_err", err_a, 1'b0);
    check("t5_rst_busy", busy_a, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    hold(1'b0, 1'b0, 3000);
    check("t5_low_no_busy", busy_a, 1'b0);
    check("t5_low_vcnt", vcnt_a, 4);
    check("t5_low_ecnt", ecnt_a, 1);
    hold(1'b0, 1'b1, 20);
    frame(1'b0, 1042, 8'h5A, 1'b1, 1042);
    hold(1'b0, 1'b1, 20);
    check("t5_vcnt", vcnt_a, 5);
    check("t5_data", data_a, 8'h5A);

    // 6: 115200 baud back-to-back 0x81, 0x7E
    hold(1'b1, 1'b1, 10);
    frame(1'b1, 87, 8'h81, 1'b1, 87);
    frame(1'b1, 87, 8'h7E, 1'b1, 87);
    hold(1'b1, 1'b1, 20);
    check("t6_vcnt", vcnt_b, 2);
    check("t6_vdata0", vdata_b[0], 8'h81);
    check("t6_vdata1", vdata_b[1], 8'h7E);
    check("t6_rx_data", data_b, 8'h7E);
    check("t6_no_err", ecnt_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
